y_write_back: RTL and testbench
===============================

Name: y_write_back

Overview:
- Write-side counterpart of the Y-matrix read path.
- Accepts updated complex Y entries (24-bit real, 24-bit imag) from the update datapath together with their row/col.
- Performs a read-modify-write on the 256-bit Y SRAM so that only the addressed slot changes.
- Signals when the final update of a change list has landed in memory.

Parameters:
- NROW, 64, number of Y-matrix rows
- NCOL, 64, number of Y-matrix columns (must be a multiple of 4)
- ADDR_W, 11, SRAM word-address width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  update request present
- wb_ready  out  1  block can accept a request this cycle
- wb_row  in  16  Y row of the entry
- wb_col  in  16  Y column of the entry
- wb_yVal  in  48  {real[23:0], img[23:0]}
- wb_last  in  1  qualifies the final request of a change list
- ysram_addr  out  ADDR_W  SRAM word address (read and write)
- ysram_re  out  1  read strobe
- ysram_rdata  in  256  read data, valid the cycle after ysram_re
- ysram_we  out  1  write strobe
- ysram_wdata  out  256  merged write word
- op_allDone  out  1  one-cycle pulse when the wb_last write completes
- op_rangeErr  out  1  sticky: an out-of-range request was dropped

Behaviour:
- Memory map:
  - word address = row*(NCOL/4) + col[..:2]
  - slot = col[1:0]
  - slot k occupies bits [64k+63:64k]: [64k+47:64k] = wb_yVal, [64k+63:64k+48] = 0
  - the other three slots pass through unchanged
- Reset (async, low), all outputs 0 except wb_ready = 1:
  - state = IDLE; op_rangeErr cleared; internal request/buffer registers cleared.
  - Asserting reset mid-operation abandons the write: ysram_we drops immediately and no partial write is issued.
- Handshake: a request is accepted on a rising edge with wb_valid && wb_ready. wb_ready = 1 only in IDLE. Row, col, value and last are captured at acceptance.
- FSM:
  - IDLE: on accept, go to RD if in range, otherwise set op_rangeErr and stay in IDLE. No SRAM access occurs for dropped requests; a dropped request with wb_last set still pulses op_allDone the next cycle.
  - RD: ysram_re = 1, ysram_addr = computed address → WAIT.
  - WAIT: capture ysram_rdata at the end of the cycle → WR.
  - WR: ysram_we = 1, same address, ysram_wdata = merged word → IDLE. If the captured last = 1, op_allDone pulses in the cycle after WR.
- Timing: accept at T, re at T+1, we at T+3, wb_ready high again at T+4. Throughput is one update per 4 cycles.
- Ordering: requests complete strictly in order. Each write finishes before the next read, so there is no RAW hazard.
- This block is the sole Y SRAM writer while an update is in progress.
- ysram_re and ysram_we are never high in the same cycle. ysram_addr = 0 when neither is asserted.
- Range check: row ≥ NROW or col ≥ NCOL is out of range. Widths are full 16 bits with no truncation before the compare.

Optional Feature:
- Macro YWB_COALESCE_EN.
- With the macro defined:
  - the block keeps the last written word and its address in a buffer (valid flag cleared on reset);
  - an accepted request to the same address skips RD/WAIT and goes IDLE → WR, merging into the buffered word;
  - latency in that case is we at T+1, wb_ready high at T+2.
- Without the macro, every request performs a full read-modify-write and no buffer exists.

Decomposition:
- Package y_pkg: ENTRY_W = 48, SLOT_W = 64, WORD_W = 256, SLOTS_PER_WORD = 4, state enum {IDLE, RD, WAIT, WR}.
- Sub-module y_wb_addr_map (combinational): (row, col) → word address, slot, out-of-range flag. Shared with the read-side address decoder.

Test Plan:
- Reset → row 2, col 5, value 48'h00000A_FFFFF6 → re at T+1 with addr 33; rdata = all-ones; we at T+3 with wdata bits [127:64] = 64'h0000_00000AFFFFF6 and all other bits 1.
- Back-to-back requests (0,0) then (0,1) with wb_valid held high → second accepted at T+4; each write touches only its own slot; two reads issued.
- Row 64, col 0 → no re/we, op_rangeErr = 1 and stays 1; a following valid request (1,3) still completes, with addr 16 and slot 3.
- Request (63,63) with wb_last = 1 → write to addr 1023, slot 3; op_allDone is a single pulse at T+4.
- reset driven low during WAIT → ysram_we never asserts, all outputs return to reset values, wb_ready = 1.
- With YWB_COALESCE_EN defined: (5,8) then (5,9) → second request has no re, we one cycle after acceptance, and the wdata retains slot 0 from the first write.

Source files
------------

// File: rtl/y_pkg.sv
// Shared types and constants for the Y-matrix SRAM write-back path.
// Holds the word/slot geometry and the read-modify-write merge helper.
package y_pkg;

    localparam int ENTRY_W        = 48;
    localparam int SLOT_W         = 64;
    localparam int WORD_W         = 256;
    localparam int SLOTS_PER_WORD = 4;
    localparam int SLOT_IDX_W     = $clog2(SLOTS_PER_WORD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2,
        WR   = 2'd3
    } wb_state_e;

    typedef logic [ENTRY_W-1:0]    entry_t;
    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [SLOT_IDX_W-1:0] slot_t;

    // Replace one 64-bit slot with a zero-padded entry; the other slots pass through.
    function automatic word_t merge_slot(input word_t word, input slot_t slot, input entry_t val);
        word_t merged;
        merged = word;
        merged[slot*SLOT_W +: SLOT_W] = {{(SLOT_W-ENTRY_W){1'b0}}, val};
        return merged;
    endfunction

endpackage

// File: rtl/y_wb_addr_map.sv
// Combinational (row, col) -> SRAM word address / slot decoder with range check.
// Shared with the read-side address decoder so both agree on the memory map.
module y_wb_addr_map
    import y_pkg::*;
#(
    parameter int NROW   = 64,
    parameter int NCOL   = 64,
    parameter int ADDR_W = 11
) (
    input  logic [15:0]       row_i,
    input  logic [15:0]       col_i,
    output logic [ADDR_W-1:0] word_addr_o,
    output slot_t             slot_o,
    output logic              range_err_o
);

    localparam int WORDS_PER_ROW = NCOL / SLOTS_PER_WORD;

    assign word_addr_o = ADDR_W'(row_i) * ADDR_W'(WORDS_PER_ROW)
                       + ADDR_W'(col_i[15:SLOT_IDX_W]);
    assign slot_o      = col_i[SLOT_IDX_W-1:0];

    // Compare at full 16-bit width so large indices cannot alias into range.
    assign range_err_o = (32'(row_i) >= 32'(NROW)) || (32'(col_i) >= 32'(NCOL));

endmodule

// File: rtl/y_write_back.sv
// Y-matrix write-back: read-modify-write of one 64-bit slot in a 256-bit SRAM word.
// Optional YWB_COALESCE_EN keeps the last written word so same-word updates skip the read.
module y_write_back
    import y_pkg::*;
#(
    parameter int NROW   = 64,
    parameter int NCOL   = 64,
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [15:0]       wb_row,
    input  logic [15:0]       wb_col,
    input  logic [47:0]       wb_yVal,
    input  logic              wb_last,
    output logic [ADDR_W-1:0] ysram_addr,
    output logic              ysram_re,
    input  logic [255:0]      ysram_rdata,
    output logic              ysram_we,
    output logic [255:0]      ysram_wdata,
    output logic              op_allDone,
    output logic              op_rangeErr
);

    wb_state_e         state_q;
    logic              ready_q;
    logic              re_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    word_t             wdata_q;
    logic              done_q;
    logic              err_q;

    logic [ADDR_W-1:0] req_addr_q;
    slot_t             req_slot_q;
    entry_t            req_val_q;
    logic              req_last_q;

    logic [ADDR_W-1:0] map_addr;
    slot_t             map_slot;
    logic              map_err;
    logic              accept;

    y_wb_addr_map #(
        .NROW   (NROW),
        .NCOL   (NCOL),
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .row_i       (wb_row),
        .col_i       (wb_col),
        .word_addr_o (map_addr),
        .slot_o      (map_slot),
        .range_err_o (map_err)
    );

    assign accept = wb_valid && ready_q;

`ifdef YWB_COALESCE_EN
    logic              buf_valid_q;
    logic [ADDR_W-1:0] buf_addr_q;
    logic              coalesce_hit;

    // wdata_q still holds the last written word, so it doubles as the buffer payload.
    assign coalesce_hit = buf_valid_q && (buf_addr_q == map_addr);
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            req_addr_q <= '0;
            req_slot_q <= '0;
            req_val_q  <= '0;
            req_last_q <= 1'b0;
`ifdef YWB_COALESCE_EN
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
`endif
        end else begin
            // Strobes, address and completion are single-cycle unless re-asserted below.
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            done_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (map_err) begin
                            err_q  <= 1'b1;
                            done_q <= wb_last;
                        end else begin
                            req_addr_q <= map_addr;
                            req_slot_q <= map_slot;
                            req_val_q  <= wb_yVal;
                            req_last_q <= wb_last;
                            ready_q    <= 1'b0;
                            addr_q     <= map_addr;
`ifdef YWB_COALESCE_EN
                            if (coalesce_hit) begin
                                state_q <= WR;
                                we_q    <= 1'b1;
                                wdata_q <= merge_slot(wdata_q, map_slot, wb_yVal);
                            end else
`endif
                            begin
                                state_q <= RD;
                                re_q    <= 1'b1;
                            end
                        end
                    end
                end

                RD: begin
                    state_q <= WAIT;
                end

                WAIT: begin
                    state_q <= WR;
                    we_q    <= 1'b1;
                    addr_q  <= req_addr_q;
                    wdata_q <= merge_slot(ysram_rdata, req_slot_q, req_val_q);
                end

                WR: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= req_last_q;
`ifdef YWB_COALESCE_EN
                    buf_valid_q <= 1'b1;
                    buf_addr_q  <= req_addr_q;
`endif
                end

                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign wb_ready    = ready_q;
    assign ysram_re    = re_q;
    assign ysram_we    = we_q;
    assign ysram_addr  = addr_q;
    assign ysram_wdata = wdata_q;
    assign op_allDone  = done_q;
    assign op_rangeErr = err_q;

    a_no_rd_wr_overlap: assert property (@(posedge clock) disable iff (!reset)
        !(ysram_re && ysram_we));

    a_addr_idle_zero: assert property (@(posedge clock) disable iff (!reset)
        (!ysram_re && !ysram_we) |-> (ysram_addr == '0));

    a_ready_only_idle: assert property (@(posedge clock) disable iff (!reset)
        wb_ready == (state_q == IDLE));

    a_range_sticky: assert property (@(posedge clock) disable iff (!reset)
        op_rangeErr |=> op_rangeErr);

endmodule

// File: tb/tb_y_write_back.sv
// Self-checking bench for y_write_back: SRAM model, spec-level timing model, per-cycle compare.
// Honours YWB_COALESCE_EN for the expected latency of same-word updates.
module tb_y_write_back;

    localparam int NROW   = 64;
    localparam int NCOL   = 64;
    localparam int ADDR_W = 11;
    localparam int WPR    = NCOL / 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MAXE   = 8192;
`ifdef YWB_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              wb_valid = 1'b0;
    logic              wb_ready;
    logic [15:0]       wb_row = '0;
    logic [15:0]       wb_col = '0;
    logic [47:0]       wb_yVal = '0;
    logic              wb_last = 1'b0;
    logic [ADDR_W-1:0] ysram_addr;
    logic              ysram_re;
    logic [255:0]      ysram_rdata = '0;
    logic              ysram_we;
    logic [255:0]      ysram_wdata;
    logic              op_allDone;
    logic              op_rangeErr;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    y_write_back #(.NROW(NROW), .NCOL(NCOL), .ADDR_W(ADDR_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_row      (wb_row),
        .wb_col      (wb_col),
        .wb_yVal     (wb_yVal),
        .wb_last     (wb_last),
        .ysram_addr  (ysram_addr),
        .ysram_re    (ysram_re),
        .ysram_rdata (ysram_rdata),
        .ysram_we    (ysram_we),
        .ysram_wdata (ysram_wdata),
        .op_allDone  (op_allDone),
        .op_rangeErr (op_rangeErr)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] init_word(input int a);
        logic [255:0] w;
        if (a == 33) return '1;
        for (int k = 0; k < 8; k++)
            w[32*k +: 32] = 32'(a) * 32'h9E3779B1 + 32'(k) * 32'h7F4A7C15 + 32'h1234;
        return w;
    endfunction

    // SRAM: one-cycle read latency, write on the strobed edge.
    logic [255:0] sram [DEPTH];
    int reads = 0;
    initial begin : sram_model
        for (int i = 0; i < DEPTH; i++) sram[i] = init_word(i);
        forever begin
            @(posedge clock);
            if (ysram_re) begin
                ysram_rdata <= sram[ysram_addr];
                reads++;
            end
            if (ysram_we) sram[ysram_addr] = ysram_wdata;
        end
    end

    // Reference model: expected outputs per clock edge, derived from the accept edge.
    logic               exp_re   [MAXE];
    logic               exp_we   [MAXE];
    logic               exp_done [MAXE];
    logic [ADDR_W-1:0]  exp_addr [MAXE];
    logic [255:0]       exp_wdata[MAXE];
    logic [255:0]       ref_mem  [DEPTH];
    int edge_n = 0;
    int free_at = 0;
    int err_edge = -1;
    int last_acc_edge = -1;
    bit pend = 1'b0;
    int pend_edge = 0;
    int pend_addr = 0;
    logic [255:0] pend_old;
    bit mb_valid = 1'b0;
    int mb_addr = 0;

    initial begin : ref_model
        int r, c, a, s, we_e;
        logic [255:0] nw;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < MAXE; i++) begin
            exp_re[i] = 0; exp_we[i] = 0; exp_done[i] = 0; exp_addr[i] = '0; exp_wdata[i] = '0;
        end
        forever begin
            @(posedge clock);
            edge_n++;
            if (edge_n + 8 >= MAXE) begin
                $display("FAIL edge_budget: edge=%0d limit=%0d", edge_n, MAXE);
                $fatal(1);
            end
            if (!reset) begin
                if (pend && edge_n <= pend_edge) ref_mem[pend_addr] = pend_old;
                pend = 0; free_at = 0; err_edge = -1; mb_valid = 0;
                for (int k = edge_n; k <= edge_n + 8; k++) begin
                    exp_re[k] = 0; exp_we[k] = 0; exp_done[k] = 0; exp_addr[k] = '0;
                end
            end else if (wb_valid && edge_n >= free_at) begin
                last_acc_edge = edge_n;
                r = int'(wb_row);
                c = int'(wb_col);
                if (r >= NROW || c >= NCOL) begin
                    if (err_edge < 0) err_edge = edge_n + 1;
                    if (wb_last) exp_done[edge_n + 1] = 1;
                end else begin
                    a = r * WPR + c / 4;
                    s = c % 4;
                    nw = ref_mem[a];
                    nw[64*s +: 64] = {16'h0, wb_yVal};
                    if (COALESCE && mb_valid && mb_addr == a) begin
                        we_e = edge_n + 1;
                    end else begin
                        we_e = edge_n + 3;
                        exp_re[edge_n + 1]   = 1;
                        exp_addr[edge_n + 1] = ADDR_W'(a);
                    end
                    exp_we[we_e]    = 1;
                    exp_addr[we_e]  = ADDR_W'(a);
                    exp_wdata[we_e] = nw;
                    if (wb_last) exp_done[we_e + 1] = 1;
                    free_at   = we_e + 1;
                    pend      = 1;
                    pend_edge = we_e;
                    pend_addr = a;
                    pend_old  = ref_mem[a];
                    ref_mem[a] = nw;
                    mb_valid  = 1;
                    mb_addr   = a;
                end
            end
        end
    end

    // Per-cycle compare, sampled on the falling edge before edge n.
    always @(negedge clock) begin : compare
        int n;
        if (!reset) begin
            check("rst_ready", 256'(wb_ready), 256'(1));
            check("rst_re", 256'(ysram_re), 256'(0));
            check("rst_we", 256'(ysram_we), 256'(0));
            check("rst_addr", 256'(ysram_addr), 256'(0));
            check("rst_wdata", ysram_wdata, 256'(0));
            check("rst_done", 256'(op_allDone), 256'(0));
            check("rst_err", 256'(op_rangeErr), 256'(0));
        end else begin
            n = edge_n + 1;
            check("ready", 256'(wb_ready), 256'(n >= free_at));
            check("re", 256'(ysram_re), 256'(exp_re[n]));
            check("we", 256'(ysram_we), 256'(exp_we[n]));
            check("addr", 256'(ysram_addr), 256'(exp_addr[n]));
            check("done", 256'(op_allDone), 256'(exp_done[n]));
            check("rangeErr", 256'(op_rangeErr), 256'(err_edge >= 0 && n >= err_edge));
            if (exp_we[n]) check("wdata", ysram_wdata, exp_wdata[n]);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] r, input logic [15:0] c, input logic [47:0] v,
                        input logic l, input bit hold, output int acc);
        wb_valid = 1'b1; wb_row = r; wb_col = c; wb_yVal = v; wb_last = l;
        acc = -1;
        for (int k = 0; k < 12 && acc < 0; k++) begin
            @(posedge clock); #1;
            if (last_acc_edge == edge_n) acc = edge_n;
        end
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL accept_timeout: row=%0d col=%0d not accepted within 12 cycles", r, c);
        end
        if (!hold) wb_valid = 1'b0;
    endtask

    function automatic logic [15:0] pick(input int lim);
        int p;
        p = int'($urandom_range(0, 99));
        if (p < 85) return 16'($urandom_range(0, lim - 1));
        if (p < 93) return 16'($urandom_range(lim, lim + 6));
        return 16'($urandom_range(256, 65535));
    endfunction

    initial begin : stim
        int t, t2, rd0, gap, mism;
        logic [255:0] w, ew;
        logic [15:0] r, c, pr, pc;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_ready_lit", 256'(wb_ready), 256'(1));
        reset = 1'b1;
        @(posedge clock); #1;

        // Single update into an all-ones word.
        send(16'd2, 16'd5, 48'h00000A_FFFFF6, 1'b0, 1'b0, t);
        @(negedge clock);
        check("t1_re", 256'(ysram_re), 256'(1));
        check("t1_raddr", 256'(ysram_addr), 256'(33));
        @(negedge clock); @(negedge clock);
        ew = '1;
        ew[127:64] = 64'h0000_0000_0AFF_FFF6;
        check("t1_we", 256'(ysram_we), 256'(1));
        check("t1_wdata", ysram_wdata, ew);
        @(negedge clock);
        check("t1_ready", 256'(wb_ready), 256'(1));

        // Back-to-back with wb_valid held.
        @(posedge clock); #1;
        rd0 = reads;
        send(16'd0, 16'd0, 48'h111111_222222, 1'b0, 1'b1, t);
        send(16'd0, 16'd1, 48'h333333_444444, 1'b0, 1'b0, t2);
        check("b2b_spacing", 256'(t2 - t), 256'(4));
        repeat (6) @(posedge clock);
        #1;
        check("b2b_reads", 256'(reads - rd0), COALESCE ? 256'(1) : 256'(2));
        w = sram[0];
        ew = init_word(0);
        check("b2b_slot0", 256'(w[63:0]), 256'(64'h0000_1111_1122_2222));
        check("b2b_slot1", 256'(w[127:64]), 256'(64'h0000_3333_3344_4444));
        check("b2b_upper", 256'(w[255:128]), 256'(ew[255:128]));

        // Out-of-range drop, then a normal request.
        send(16'd64, 16'd0, 48'hABCDEF_012345, 1'b0, 1'b0, t);
        @(negedge clock);
        check("oor_err", 256'(op_rangeErr), 256'(1));
        check("oor_re", 256'(ysram_re), 256'(0));
        @(posedge clock); #1;
        send(16'd1, 16'd3, 48'h0F0F0F_F0F0F0, 1'b0, 1'b0, t);
        @(negedge clock);
        check("oor_next_addr", 256'(ysram_addr), 256'(16));
        repeat (5) @(posedge clock);
        #1;
        w = sram[16];
        ew = init_word(16);
        check("oor_slot3", 256'(w[255:192]), 256'(64'h0000_0F0F_0FF0_F0F0));
        check("oor_low", 256'(w[191:0]), 256'(ew[191:0]));
        check("oor_sticky", 256'(op_rangeErr), 256'(1));

        // Last entry of the matrix with wb_last.
        send(16'd63, 16'd63, 48'h7FFFFF_800001, 1'b1, 1'b0, t);
        @(negedge clock);
        check("last_raddr", 256'(ysram_addr), 256'(1023));
        @(negedge clock); @(negedge clock);
        check("last_waddr", 256'(ysram_addr), 256'(1023));
        @(negedge clock);
        check("last_done", 256'(op_allDone), 256'(1));
        @(negedge clock);
        check("last_done_pulse", 256'(op_allDone), 256'(0));

        // Reset while waiting for read data.
        @(posedge clock); #1;
        send(16'd10, 16'd10, 48'h555555_AAAAAA, 1'b0, 1'b0, t);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        check("rstw_we", 256'(ysram_we), 256'(0));
        check("rstw_ready", 256'(wb_ready), 256'(1));
        check("rstw_err", 256'(op_rangeErr), 256'(0));
        repeat (2) begin
            @(posedge clock); #1;
            check("rstw_we_hold", 256'(ysram_we), 256'(0));
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rstw_mem", sram[162], init_word(162));

        // Two updates to the same word.
        send(16'd5, 16'd8, 48'h0A0A0A_0B0B0B, 1'b0, 1'b1, t);
        send(16'd5, 16'd9, 48'h0C0C0C_0D0D0D, 1'b0, 1'b0, t2);
        @(negedge clock);
`ifdef YWB_COALESCE_EN
        check("coal_no_re", 256'(ysram_re), 256'(0));
        check("coal_we", 256'(ysram_we), 256'(1));
        w = ysram_wdata;
        check("coal_slot0", 256'(w[63:0]), 256'(64'h0000_0A0A_0A0B_0B0B));
        check("coal_slot1", 256'(w[127:64]), 256'(64'h0000_0C0C_0C0D_0D0D));
`else
        check("same_word_re", 256'(ysram_re), 256'(1));
        check("same_word_addr", 256'(ysram_addr), 256'(82));
`endif

        // Randomized traffic, including coalescing candidates and out-of-range indices.
        repeat (4) @(posedge clock);
        #1;
        pr = 16'd0; pc = 16'd0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 3 && pr < 16'(NROW) && pc < 16'(NCOL)) begin
                r = pr;
                c = {pc[15:2], 2'($urandom_range(0, 3))};
            end else begin
                r = pick(NROW);
                c = pick(NCOL);
            end
            gap = int'($urandom_range(0, 3));
            send(r, c, 48'({$urandom, $urandom}), 1'($urandom_range(0, 4) == 0), gap == 0, t);
            pr = r; pc = c;
            if (gap > 0) repeat (gap) begin
                @(posedge clock); #1;
            end
        end
        wb_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1;

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) mism++;
        check("mem_image", 256'(mism), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
